mem_align_unit: RTL and testbench
=================================

Name: mem_align_unit

Overview:
- Sits between the pipeline memory stage and data_mem. Drives all data_mem ports.
- Aligned loads and stores pass straight through in one cycle.
- Misaligned halfword and word accesses are split into sequential byte accesses. The pipeline is stalled until the last beat, and load bytes are reassembled into one little-endian result.

Parameters:
- SPLIT_EN, 1: 1 = split misaligned accesses into beats; 0 = always pass through, no stalls.
- DATA_WIDTH, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  memory stage has a load or store this cycle
- ReqWE  in  1  1 = store, 0 = load
- ReqWidth  in  2  width code: 00 word, 10 halfword, 01 byte, 11 treated as word
- ReqAddr  in  32  byte address
- ReqWD  in  32  store data, right-aligned
- Stall  out  1  hold the memory stage and all earlier stages
- RespValid  out  1  load data on RespRD is final this cycle
- RespRD  out  32  load result, zero-extended (sign extension is done downstream)
- MemWE  out  1  to data_mem WE
- MemWidthSrc  out  2  to data_mem WidthSrc
- MemA  out  32  to data_mem A
- MemWD  out  32  to data_mem WD
- MemRD  in  32  from data_mem RD (combinational read of MemA)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state: IDLE, beat counter 0, captured request registers 0, assembly register 0.
  - Outputs in IDLE with ReqValid=0: Stall=0, RespValid=0, MemWE=0, MemA=ReqAddr, MemWidthSrc=ReqWidth, MemWD=ReqWD, RespRD=MemRD.
- Misaligned definition (mis): word (00/11) with ReqAddr[1:0]!=0, or halfword (10) with ReqAddr[0]=1. Bytes are never misaligned. N = 4 for word, 2 for halfword.
- IDLE, ReqValid=1, not mis (or SPLIT_EN=0): pure pass-through.
  - MemWE=ReqWE, MemWidthSrc=ReqWidth, MemA=ReqAddr, MemWD=ReqWD.
  - Load: RespValid=1 and RespRD=MemRD in the same cycle. Store: RespValid=0.
  - Stall=0 and the state stays IDLE.
- IDLE, ReqValid=1, mis (SPLIT_EN=1): issue beat 0 combinationally in this cycle.
  - Beat 0 signals: MemWidthSrc=01, MemA=ReqAddr, MemWE=ReqWE, MemWD[7:0]=ReqWD[7:0].
  - Stall=1.
  - On the clock edge, capture ReqWE, ReqAddr, ReqWD and N; capture MemRD[7:0] into assembly byte 0; set beat=1; go to SPLIT.
- SPLIT, beat k: MemWidthSrc=01, MemA=capAddr+k (32-bit add, wraps mod 2^32), MemWE=capWE, MemWD[7:0]=capWD[8k+7:8k].
  - For k<N-1: Stall=1 and RespValid=0; on the clock edge, assembly byte k takes MemRD[7:0] and beat increments.
  - For k=N-1 (final beat): Stall=0. For a load, RespValid=1 and RespRD = assembled bytes 0..N-2 with MemRD[7:0] in byte N-1; upper bytes are 0 for halfwords.
  - After the final beat the state returns to IDLE and the counter clears.
- Total latency for a misaligned access is N cycles, with Stall high for the first N-1.
- The Req* inputs are ignored in SPLIT. A new request is accepted only in the cycle after the final beat.
- Back-to-back misaligned requests are legal; there are no idle bubbles beyond the N beats.
- Reset mid-split: return to IDLE at once and clear all registers. Bytes already written remain; no further beats are issued.
- Stores in SPLIT never assert RespValid.

Test Plan:
- Aligned path: word store 0xDEADBEEF at 0x10, then word load from 0x10 → each completes in 1 cycle with Stall=0; load gives RespValid=1, RespRD=0xDEADBEEF.
- Misaligned word store: 0xAABBCCDD at 0x21 → 4 beats, Stall=1 for 3 cycles; byte loads from 0x21..0x24 return 0xDD, 0xCC, 0xBB, 0xAA.
- Misaligned word load: from 0x21 after the store above → RespValid=1 only on cycle 4, RespRD=0xAABBCCDD; MemA sequence is 0x21, 0x22, 0x23, 0x24.
- Halfword split versus no split:
  - Halfword store 0x1234 at 0x33 then load from 0x33 → 2 beats each, RespRD=0x00001234.
  - Halfword at 0x32 → single-cycle pass-through with MemWidthSrc=10.
- Reset mid-operation: assert reset during beat 2 of a word store 0x11223344 at 0x41 → Stall=0 and IDLE immediately; bytes at 0x41..0x42 = 0x44, 0x33; 0x43..0x44 unchanged.
- SPLIT_EN=0: word store at 0x05 → one cycle, MemWidthSrc=00, MemA=0x05, Stall=0.

Source files
------------

// File: rtl/mem_align_unit.sv
// Memory alignment shim between the pipeline memory stage and data_mem.
// Aligned accesses pass through; misaligned halfword/word accesses become byte beats.
module mem_align_unit #(
   parameter int unsigned SPLIT_EN   = 1,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ReqValid,
   input  logic                  ReqWE,
   input  logic [1:0]            ReqWidth,
   input  logic [DATA_WIDTH-1:0] ReqAddr,
   input  logic [DATA_WIDTH-1:0] ReqWD,
   output logic                  Stall,
   output logic                  RespValid,
   output logic [DATA_WIDTH-1:0] RespRD,
   output logic                  MemWE,
   output logic [1:0]            MemWidthSrc,
   output logic [DATA_WIDTH-1:0] MemA,
   output logic [DATA_WIDTH-1:0] MemWD,
   input  logic [DATA_WIDTH-1:0] MemRD
);

   typedef enum logic {
      IDLE,
      SPLIT
   } state_t;

   localparam logic [1:0] W_BYTE = 2'b01;
   localparam logic [1:0] W_HALF = 2'b10;

   state_t                state_q, state_d;
   logic [1:0]            beat_q, beat_d;
   logic [1:0]            last_q, last_d;
   logic                  cap_we_q, cap_we_d;
   logic [DATA_WIDTH-1:0] cap_addr_q, cap_addr_d;
   logic [DATA_WIDTH-1:0] cap_wd_q, cap_wd_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;

   logic                  is_word, is_half, mis, last_beat;
   logic [7:0]            wr_byte;
   logic [DATA_WIDTH-1:0] rd_merged;

   always_comb begin
      is_half   = (ReqWidth == W_HALF);
      is_word   = (ReqWidth == 2'b00) || (ReqWidth == 2'b11);
      mis       = (SPLIT_EN != 0) && ReqValid &&
                  ((is_word && (ReqAddr[1:0] != 2'b00)) || (is_half && ReqAddr[0]));
      last_beat = (beat_q == last_q);
      wr_byte   = cap_wd_q[{beat_q, 3'b000} +: 8];
      // Final-beat result: earlier beats come from asm_q, the current byte straight from MemRD.
      rd_merged = asm_q;
      rd_merged[{beat_q, 3'b000} +: 8] = MemRD[7:0];
   end

   always_comb begin
      Stall       = 1'b0;
      RespValid   = 1'b0;
      RespRD      = MemRD;
      MemWE       = 1'b0;
      MemWidthSrc = ReqWidth;
      MemA        = ReqAddr;
      MemWD       = ReqWD;

      state_d     = state_q;
      beat_d      = beat_q;
      last_d      = last_q;
      cap_we_d    = cap_we_q;
      cap_addr_d  = cap_addr_q;
      cap_wd_d    = cap_wd_q;
      asm_d       = asm_q;

      if (state_q == IDLE) begin
         if (mis) begin
            MemWidthSrc = W_BYTE;
            MemWE       = ReqWE;
            MemWD       = '0;
            MemWD[7:0]  = ReqWD[7:0];
            Stall       = 1'b1;
            state_d     = SPLIT;
            beat_d      = 2'd1;
            last_d      = is_word ? 2'd3 : 2'd1;
            cap_we_d    = ReqWE;
            cap_addr_d  = ReqAddr;
            cap_wd_d    = ReqWD;
            // Upper bytes cleared so a halfword result is zero-extended.
            asm_d       = '0;
            asm_d[7:0]  = MemRD[7:0];
         end else begin
            MemWE     = ReqValid & ReqWE;
            RespValid = ReqValid & ~ReqWE;
         end
      end else begin
         MemWidthSrc = W_BYTE;
         MemA        = cap_addr_q + DATA_WIDTH'(beat_q);
         MemWE       = cap_we_q;
         MemWD       = '0;
         MemWD[7:0]  = wr_byte;
         if (last_beat) begin
            RespValid = ~cap_we_q;
            RespRD    = rd_merged;
            state_d   = IDLE;
            beat_d    = 2'd0;
         end else begin
            Stall  = 1'b1;
            asm_d  = rd_merged;
            beat_d = beat_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         last_q     <= '0;
         cap_we_q   <= 1'b0;
         cap_addr_q <= '0;
         cap_wd_q   <= '0;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         last_q     <= last_d;
         cap_we_q   <= cap_we_d;
         cap_addr_q <= cap_addr_d;
         cap_wd_q   <= cap_wd_d;
         asm_q      <= asm_d;
      end
   end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed per-cycle vector bench for mem_align_unit with a byte-addressed data_mem model.
module tb_mem_align_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ReqValid, ReqWE;
   logic [1:0]  ReqWidth;
   logic [31:0] ReqAddr, ReqWD;
   logic        Stall, RespValid, MemWE;
   logic [31:0] RespRD, MemA, MemWD, MemRD;
   logic [1:0]  MemWidthSrc;

   logic        ns_valid, ns_we;
   logic [1:0]  ns_width;
   logic [31:0] ns_addr, ns_wd;
   logic        ns_stall, ns_rv, ns_mwe;
   logic [31:0] ns_rd, ns_ma, ns_mwd;
   logic [1:0]  ns_ws;
   logic [31:0] ns_mrd;

   logic        mem_clr;
   logic [7:0]  mem [0:255];

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   mem_align_unit #(.SPLIT_EN(1), .DATA_WIDTH(32)) u_dut (
      .clk(clk), .reset(reset),
      .ReqValid(ReqValid), .ReqWE(ReqWE), .ReqWidth(ReqWidth),
      .ReqAddr(ReqAddr), .ReqWD(ReqWD),
      .Stall(Stall), .RespValid(RespValid), .RespRD(RespRD),
      .MemWE(MemWE), .MemWidthSrc(MemWidthSrc), .MemA(MemA), .MemWD(MemWD),
      .MemRD(MemRD)
   );

   mem_align_unit #(.SPLIT_EN(0), .DATA_WIDTH(32)) u_nosplit (
      .clk(clk), .reset(reset),
      .ReqValid(ns_valid), .ReqWE(ns_we), .ReqWidth(ns_width),
      .ReqAddr(ns_addr), .ReqWD(ns_wd),
      .Stall(ns_stall), .RespValid(ns_rv), .RespRD(ns_rd),
      .MemWE(ns_mwe), .MemWidthSrc(ns_ws), .MemA(ns_ma), .MemWD(ns_mwd),
      .MemRD(ns_mrd)
   );

   assign ns_mrd = 32'h0BAD_F00D;

   // data_mem: little-endian, combinational read of four bytes starting at A
   assign MemRD = {mem[MemA[7:0] + 8'd3], mem[MemA[7:0] + 8'd2],
                   mem[MemA[7:0] + 8'd1], mem[MemA[7:0]]};

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (MemWE) begin
         mem[MemA[7:0]] <= MemWD[7:0];
         if (MemWidthSrc != 2'b01) mem[MemA[7:0] + 8'd1] <= MemWD[15:8];
         if (MemWidthSrc == 2'b00 || MemWidthSrc == 2'b11) begin
            mem[MemA[7:0] + 8'd2] <= MemWD[23:16];
            mem[MemA[7:0] + 8'd3] <= MemWD[31:24];
         end
      end
   end

   typedef struct {
      logic        v;
      logic        we;
      logic [1:0]  w;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e_stall;
      logic        e_rv;
      logic        e_we;
      logic [1:0]  e_ws;
      logic [31:0] e_a;
      logic [31:0] e_wd;
      logic [31:0] e_rd;
      logic [31:0] rd_mask;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic v, logic we, logic [1:0] w, logic [31:0] a, logic [31:0] wd,
                               logic es, logic erv, logic ewe, logic [1:0] ews, logic [31:0] ea,
                               logic [31:0] ewd, logic [31:0] erd, logic [31:0] msk);
      vec_t r;
      r.v = v; r.we = we; r.w = w; r.a = a; r.wd = wd;
      r.e_stall = es; r.e_rv = erv; r.e_we = ewe; r.e_ws = ews; r.e_a = ea;
      r.e_wd = ewd; r.e_rd = erd; r.rd_mask = msk;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] wd);
      ReqValid = v; ReqWE = we; ReqWidth = w; ReqAddr = a; ReqWD = wd;
   endtask

   task automatic byte_load(input logic [31:0] a, input logic [7:0] exp);
      @(negedge clk);
      drive(1'b1, 1'b0, 2'b01, a, 32'h0);
      #2;
      check($sformatf("rst_seq stall@%h", a), {31'b0, Stall}, 32'd0);
      check($sformatf("rst_seq byte@%h", a), {24'b0, RespRD[7:0]}, {24'b0, exp});
   endtask

   initial begin
      reset = 1'b1; mem_clr = 1'b1;
      drive(1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
      ns_valid = 1'b0; ns_we = 1'b0; ns_width = 2'b00; ns_addr = 32'h0; ns_wd = 32'h0;

      //           v  we  w      addr    wd            stall rv we ws     A       WD           RD           mask
      vq.push_back(mk(0, 0, 2'b00, 32'h10, 32'h0,        0, 0, 0, 2'b00, 32'h10, 32'h0,       32'h0,       32'hFFFFFFFF));
      vq.push_back(mk(1, 1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0,      32'h0));
      vq.push_back(mk(1, 0, 2'b00, 32'h10, 32'h0,        0, 1, 0, 2'b00, 32'h10, 32'h0,       32'hDEADBEEF, 32'hFFFFFFFF));
      vq.push_back(mk(1, 1, 2'b00, 32'h21, 32'hAABBCCDD, 1, 0, 1, 2'b01, 32'h21, 32'hDD,      32'h0,       32'h0));
      vq.push_back(mk(1, 1, 2'b00, 32'h21, 32'hAABBCCDD, 1, 0, 1, 2'b01, 32'h22, 32'hCC,      32'h0,       32'h0));
      vq.push_back(mk(1, 1, 2'b00, 32'h21, 32'hAABBCCDD, 1, 0, 1, 2'b01, 32'h23, 32'hBB,      32'h0,       32'h0));
      vq.push_back(mk(0, 0, 2'b00, 32'h21, 32'hAABBCCDD, 0, 0, 1, 2'b01, 32'h24, 32'hAA,      32'h0,       32'h0));
      vq.push_back(mk(1, 0, 2'b01, 32'h21, 32'h0,        0, 1, 0, 2'b01, 32'h21, 32'h0,       32'hDD,      32'hFF));
      vq.push_back(mk(1, 0, 2'b01, 32'h22, 32'h0,        0, 1, 0, 2'b01, 32'h22, 32'h0,       32'hCC,      32'hFF));
      vq.push_back(mk(1, 0, 2'b01, 32'h23, 32'h0,        0, 1, 0, 2'b01, 32'h23, 32'h0,       32'hBB,      32'hFF));
      vq.push_back(mk(1, 0, 2'b01, 32'h24, 32'h0,        0, 1, 0, 2'b01, 32'h24, 32'h0,       32'hAA,      32'hFF));
      vq.push_back(mk(1, 0, 2'b00, 32'h21, 32'h0,        1, 0, 0, 2'b01, 32'h21, 32'h0,       32'h0,       32'h0));
      vq.push_back(mk(1, 1, 2'b00, 32'h99, 32'hFFFFFFFF, 1, 0, 0, 2'b01, 32'h22, 32'h0,       32'h0,       32'h0));
      vq.push_back(mk(1, 1, 2'b10, 32'h98, 32'hFFFFFFFF, 1, 0, 0, 2'b01, 32'h23, 32'h0,       32'h0,       32'h0));
      vq.push_back(mk(1, 0, 2'b00, 32'h21, 32'h0,        0, 1, 0, 2'b01, 32'h24, 32'h0,       32'hAABBCCDD, 32'hFFFFFFFF));
      vq.push_back(mk(1, 1, 2'b10, 32'h33, 32'h1234,     1, 0, 1, 2'b01, 32'h33, 32'h34,      32'h0,       32'h0));
      vq.push_back(mk(0, 0, 2'b00, 32'h33, 32'h1234,     0, 0, 1, 2'b01, 32'h34, 32'h12,      32'h0,       32'h0));
      vq.push_back(mk(1, 0, 2'b10, 32'h33, 32'h0,        1, 0, 0, 2'b01, 32'h33, 32'h0,       32'h0,       32'h0));
      vq.push_back(mk(0, 0, 2'b10, 32'h33, 32'h0,        0, 1, 0, 2'b01, 32'h34, 32'h0,       32'h00001234, 32'hFFFFFFFF));
      vq.push_back(mk(1, 1, 2'b10, 32'h32, 32'h5678,     0, 0, 1, 2'b10, 32'h32, 32'h5678,    32'h0,       32'h0));
      vq.push_back(mk(1, 0, 2'b10, 32'h32, 32'h0,        0, 1, 0, 2'b10, 32'h32, 32'h0,       32'h5678,    32'h0000FFFF));
      vq.push_back(mk(0, 0, 2'b00, 32'h10, 32'h0,        0, 0, 0, 2'b00, 32'h10, 32'h0,       32'hDEADBEEF, 32'hFFFFFFFF));

      repeat (2) @(negedge clk);
      reset = 1'b0; mem_clr = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].v, vq[i].we, vq[i].w, vq[i].a, vq[i].wd);
         #2;
         check($sformatf("v%0d Stall", i), {31'b0, Stall}, {31'b0, vq[i].e_stall});
         check($sformatf("v%0d RespValid", i), {31'b0, RespValid}, {31'b0, vq[i].e_rv});
         check($sformatf("v%0d MemWE", i), {31'b0, MemWE}, {31'b0, vq[i].e_we});
         check($sformatf("v%0d MemWidthSrc", i), {30'b0, MemWidthSrc}, {30'b0, vq[i].e_ws});
         check($sformatf("v%0d MemA", i), MemA, vq[i].e_a);
         if (vq[i].e_we) begin
            if (vq[i].e_ws == 2'b01)
               check($sformatf("v%0d MemWD byte", i), {24'b0, MemWD[7:0]}, vq[i].e_wd);
            else
               check($sformatf("v%0d MemWD", i), MemWD, vq[i].e_wd);
         end
         if (vq[i].rd_mask != 32'h0)
            check($sformatf("v%0d RespRD", i), RespRD & vq[i].rd_mask, vq[i].e_rd);
      end

      // Reset during beat 2 of a misaligned word store: bytes 0x41..0x42 land, 0x43..0x44 keep old values.
      @(negedge clk); drive(1'b1, 1'b1, 2'b01, 32'h43, 32'h5A);
      @(negedge clk); drive(1'b1, 1'b1, 2'b01, 32'h44, 32'hA5);
      @(negedge clk); drive(1'b1, 1'b1, 2'b00, 32'h41, 32'h11223344);
      #2;
      check("rst_seq beat0 MemA", MemA, 32'h41);
      check("rst_seq beat0 Stall", {31'b0, Stall}, 32'd1);
      @(negedge clk); #2;
      check("rst_seq beat1 MemA", MemA, 32'h42);
      check("rst_seq beat1 MemWD", {24'b0, MemWD[7:0]}, 32'h33);
      @(negedge clk); #2;
      check("rst_seq beat2 MemA", MemA, 32'h43);
      check("rst_seq beat2 Stall", {31'b0, Stall}, 32'd1);
      reset = 1'b1;
      ReqValid = 1'b0;
      #1;
      check("rst_seq async Stall", {31'b0, Stall}, 32'd0);
      check("rst_seq async MemWE", {31'b0, MemWE}, 32'd0);
      check("rst_seq async MemA", MemA, 32'h41);
      @(negedge clk);
      reset = 1'b0;
      byte_load(32'h41, 8'h44);
      byte_load(32'h42, 8'h33);
      byte_load(32'h43, 8'h5A);
      byte_load(32'h44, 8'hA5);

      // SPLIT_EN=0 instance: misaligned accesses pass straight through.
      @(negedge clk);
      drive(1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
      ns_valid = 1'b1; ns_we = 1'b1; ns_width = 2'b00; ns_addr = 32'h05; ns_wd = 32'hCAFEF00D;
      #2;
      check("nosplit st Stall", {31'b0, ns_stall}, 32'd0);
      check("nosplit st MemWidthSrc", {30'b0, ns_ws}, 32'd0);
      check("nosplit st MemA", ns_ma, 32'h05);
      check("nosplit st MemWE", {31'b0, ns_mwe}, 32'd1);
      check("nosplit st MemWD", ns_mwd, 32'hCAFEF00D);
      @(negedge clk);
      ns_we = 1'b0; ns_width = 2'b10; ns_addr = 32'h33;
      #2;
      check("nosplit ld Stall", {31'b0, ns_stall}, 32'd0);
      check("nosplit ld RespValid", {31'b0, ns_rv}, 32'd1);
      check("nosplit ld RespRD", ns_rd, 32'h0BADF00D);
      check("nosplit ld MemWidthSrc", {30'b0, ns_ws}, 32'd2);
      @(negedge clk);
      ns_valid = 1'b0;
      #2;
      check("nosplit idle Stall", {31'b0, ns_stall}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
